// File: rtl/sync_fifo_v2_pkg.sv
// Shared helpers for the sync_fifo_v2 slice.
// Holds the pointer-width helper used for parameter defaults.
package sync_fifo_v2_pkg;

  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_v2_mem.sv
// Simple dual-port storage for sync_fifo_v2.
// One write port, one asynchronous read port, no reset.
module sync_fifo_v2_mem #(
  parameter int data_width = 8,
  parameter int fifo_depth = 32,
  parameter int addr_width = 5
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [addr_width-1:0] waddr_i,
  input  logic [data_width-1:0] wdata_i,
  input  logic [addr_width-1:0] raddr_i,
  output logic [data_width-1:0] rdata_o
);

  logic [data_width-1:0] mem_q [fifo_depth];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with count, almost flags, sticky errors
// and a selectable first-word-fall-through read mode.
module sync_fifo_v2
  import sync_fifo_v2_pkg::*;
#(
  parameter int data_width = 8,
  parameter int fifo_depth = 32,
  parameter int addr_width = log2(fifo_depth),
  parameter bit fwft       = 1'b0,
  parameter int af_level   = fifo_depth - 2,
  parameter int ae_level   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [data_width-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [data_width-1:0] dout,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = addr_width + 1;
  localparam logic [PW-1:0] AF = PW'(af_level);
  localparam logic [PW-1:0] AE = PW'(ae_level);

  if ((fifo_depth < 2) || ((fifo_depth & (fifo_depth - 1)) != 0))
  begin : g_bad_depth
    $error("fifo_depth must be a power of two >= 2");
  end
  if (af_level > fifo_depth) begin : g_bad_af
    $error("af_level must be <= fifo_depth");
  end
  if (ae_level >= fifo_depth) begin : g_bad_ae
    $error("ae_level must be < fifo_depth");
  end

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;
  logic [data_width-1:0] head;
  logic wr_ok, rd_ok;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[addr_width-1:0] == rptr_q[addr_width-1:0])
              && (wptr_q[addr_width] != rptr_q[addr_width]);

  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    ovf_d  = ovf_q | (wr_en & ~wr_ok);
    udf_d  = udf_q | (rd_en & empty);
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) begin
      rptr_d = rptr_q + 1'b1;
      dout_d = head;
    end
    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // A write while full lands in the slot the same-cycle pop frees;
  // the async read still returns the old head before the edge.
  sync_fifo_v2_mem #(
    .data_width(data_width),
    .fifo_depth(fifo_depth),
    .addr_width(addr_width)
  ) u_mem (
    .clk    (clk),
    .we_i   (wr_ok & rst_n),
    .waddr_i(wptr_q[addr_width-1:0]),
    .wdata_i(din),
    .raddr_i(rptr_q[addr_width-1:0]),
    .rdata_o(head)
  );

  assign dout         = fwft ? head : dout_q;
  assign count        = cnt_q;
  assign almost_full  = (cnt_q >= AF);
  assign almost_empty = (cnt_q <= AE);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Bench for sync_fifo_v2: both read modes share one stimulus
// stream and are checked against a queue-based model.
module tb_sync_fifo_v2;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic clk, rst_n, wr_en, rd_en;
  logic [DW-1:0] din;

  logic full0, af0, empty0, ae0, ovf0, udf0;
  logic [DW-1:0] dout0;
  logic [2:0] count0;
  logic full1, af1, empty1, ae1, ovf1, udf1;
  logic [DW-1:0] dout1;
  logic [2:0] count1;

  int checks = 0;
  int errors = 0;

  int q[$];
  int m_dout0;
  bit m_ovf, m_udf;

  sync_fifo_v2 #(
    .data_width(DW), .fifo_depth(DEPTH), .fwft(1'b0),
    .af_level(AF), .ae_level(AE)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din),
    .full(full0), .almost_full(af0), .rd_en(rd_en),
    .dout(dout0), .empty(empty0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_v2 #(
    .data_width(DW), .fifo_depth(DEPTH), .fwft(1'b1),
    .af_level(AF), .ae_level(AE)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din),
    .full(full1), .almost_full(af1), .rd_en(rd_en),
    .dout(dout1), .empty(empty1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(udf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count0", int'(count0), n);
    chk("count1", int'(count1), n);
    chk("empty0", int'(empty0), int'(n == 0));
    chk("empty1", int'(empty1), int'(n == 0));
    chk("full0", int'(full0), int'(n == DEPTH));
    chk("full1", int'(full1), int'(n == DEPTH));
    chk("afull0", int'(af0), int'(n >= AF));
    chk("afull1", int'(af1), int'(n >= AF));
    chk("aempty0", int'(ae0), int'(n <= AE));
    chk("aempty1", int'(ae1), int'(n <= AE));
    chk("ovf0", int'(ovf0), int'(m_ovf));
    chk("ovf1", int'(ovf1), int'(m_ovf));
    chk("udf0", int'(udf0), int'(m_udf));
    chk("udf1", int'(udf1), int'(m_udf));
    chk("dout0", int'(dout0), m_dout0);
    if (n > 0) chk("dout1", int'(dout1), q[0]);
  endtask

  task automatic step(input bit rst, input bit we,
                      input bit re, input int d);
    bit rok, wok;
    @(negedge clk);
    rst_n = ~rst;
    wr_en = we;
    rd_en = re;
    din   = DW'(d);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_dout0 = 0;
      m_ovf = 0;
      m_udf = 0;
    end else begin
      rok = re && (q.size() > 0);
      wok = we && ((q.size() < DEPTH) || rok);
      if (we && !wok) m_ovf = 1;
      if (re && q.size() == 0) m_udf = 1;
      if (rok) m_dout0 = q.pop_front();
      if (wok) q.push_back(d & 8'hFF);
    end
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    m_dout0 = 0;
    m_ovf = 0;
    m_udf = 0;

    step(1, 1, 0, 8'h99);
    step(1, 1, 0, 8'h99);

    // Fill, overflow, drain.
    step(0, 1, 0, 8'h11);
    step(0, 1, 0, 8'h22);
    step(0, 1, 0, 8'h33);
    step(0, 1, 0, 8'h44);
    step(0, 1, 0, 8'h55);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

    // Simultaneous read/write when full, then when empty.
    step(1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, 0, i * 8'h11);
    step(0, 1, 1, 8'h66);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    step(0, 1, 1, 8'h77);
    step(0, 0, 1, 0);

    // Wrap with write/read pairs.
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, i);
      step(0, 0, 1, 0);
    end

    // Fall-through behaviour and sticky underflow.
    step(0, 1, 0, 8'hA5);
    step(0, 1, 0, 8'h5A);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 8'h01);
    step(0, 0, 1, 0);

    // Random traffic with rare resets.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 1),
           $urandom_range(0, 1), int'($urandom_range(0, 255)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
